// File: rtl/serial_reduce_using_mux.sv
// Serial packet reducer: folds a last-framed bit stream to one bit with AND/OR/XOR
// built only from mux cells. Optional beat counter enabled by SERIAL_REDUCE_LEN_EN.

module mux (
  input  logic a0,
  input  logic a1,
  input  logic sel,
  output logic y
);
  assign y = sel ? a1 : a0;
endmodule

module serial_reduce_using_mux #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic             up_data,
  input  logic             up_last,
  input  logic [1:0]       up_op,
  output logic             up_ready,
  output logic             down_valid,
  output logic             down_data,
  output logic [LEN_W-1:0] down_len,
  input  logic             down_ready
);

  typedef enum logic {IDLE, ACC} state_t;

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic       acc_q, acc_d;
  logic       dv_q, dv_d;
  logic       dd_q, dd_d;

  logic beat, take, idle;
  logic not_acc, and_y, or_y, xor_y, lo_y, hi_y, fold_y, acc_next;

  assign down_valid = dv_q;
  assign down_data  = dd_q;
  assign up_ready   = !dv_q || down_ready;
  assign beat       = up_valid && up_ready;
  assign take       = dv_q && down_ready;
  assign idle       = (state_q == IDLE);

  // Gate library from muxes: AND, OR, NOT, XOR of accumulator with incoming bit
  mux u_not (.a0(1'b1),  .a1(1'b0),    .sel(acc_q),   .y(not_acc));
  mux u_and (.a0(1'b0),  .a1(acc_q),   .sel(up_data), .y(and_y));
  mux u_or  (.a0(acc_q), .a1(1'b1),    .sel(up_data), .y(or_y));
  mux u_xor (.a0(acc_q), .a1(not_acc), .sel(up_data), .y(xor_y));

  // Op select: 00 AND, 01 OR, 10 XOR, 11 AND
  mux u_lo  (.a0(and_y), .a1(or_y),  .sel(op_q[0]), .y(lo_y));
  mux u_hi  (.a0(xor_y), .a1(and_y), .sel(op_q[0]), .y(hi_y));
  mux u_op  (.a0(lo_y),  .a1(hi_y),  .sel(op_q[1]), .y(fold_y));

  // First beat of a packet seeds the accumulator with the raw bit
  mux u_first (.a0(fold_y), .a1(up_data), .sel(idle), .y(acc_next));

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    dv_d    = dv_q;
    dd_d    = dd_q;
    if (take) dv_d = 1'b0;
    if (beat) begin
      acc_d = acc_next;
      if (idle) op_d = up_op;
      if (up_last) begin
        dv_d    = 1'b1;
        dd_d    = acc_next;
        state_d = IDLE;
      end else begin
        state_d = ACC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      acc_q   <= 1'b0;
      dv_q    <= 1'b0;
      dd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      dv_q    <= dv_d;
      dd_q    <= dd_d;
    end
  end

`ifdef SERIAL_REDUCE_LEN_EN
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d, cnt_inc;

  // Saturating beat count; restarts at one on the first beat of each packet
  assign cnt_inc = (cnt_q == {LEN_W{1'b1}}) ? cnt_q : cnt_q + LEN_W'(1);

  always_comb begin
    cnt_d = cnt_q;
    len_d = len_q;
    if (beat) begin
      cnt_d = idle ? LEN_W'(1) : cnt_inc;
      if (up_last) len_d = cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      len_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  end

  assign down_len = len_q;
`else
  assign down_len = '0;
`endif

endmodule
